mesh_phase_ctrl: RTL and testbench
==================================

# mesh_phase_ctrl

Sequencer for the sorting mesh: it drives one write operation through the phases load, sort, route, write and done. It sits beside `mesh` and broadcasts phase enables and a step index to every PE. It runs the odd-even sort for exactly `SORT_CYCLES` cycles and the route phase for `ROUTE_CYCLES` cycles, then commits the write and reports completion to the host.

## Interface
Parameters:
- `N`, 16, number of PEs in the mesh.
- `SQRT_N`, 4, mesh side length (informational; sets the `ROUTE_CYCLES` default).
- `SORT_CYCLES`, 21, number of sort-phase cycles.
- `ROUTE_CYCLES`, 2*(SQRT_N-1), number of route-phase cycles; must be ≥1.
- `STEP_W`, 5, step counter width; must satisfy 2^STEP_W ≥ max(SORT_CYCLES, ROUTE_CYCLES).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  host request to begin an operation; sampled only in IDLE.
- `abort`  in  1  cancel the operation in progress; returns to IDLE.
- `pe_ready`  in  N  per-PE "operand loaded" flags.
- `phase`  out  3  current state code.
- `step`  out  STEP_W  cycle index within SORT/ROUTE; 0 elsewhere.
- `sort_en`  out  1  high throughout SORT.
- `sort_odd`  out  1  equals `step[0]` during SORT (odd/even compare pairing); 0 elsewhere.
- `route_en`  out  1  high throughout ROUTE.
- `write_en`  out  1  single-cycle memory commit strobe.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle completion pulse.
- `op_count`  out  8  count of completed operations; wraps 255→0.

## Operation
- The FSM is Moore-style; all outputs are registered or decoded only from state/step.
- State codes: IDLE=0, LOAD=1, SORT=2, ROUTE=3, WRITE=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next cycle.
- **IDLE:** `start`=1 → LOAD.
- **LOAD:** `&pe_ready`=1 → SORT with `step`=0. Otherwise stay in LOAD, with no timeout.
- **SORT:** `step` increments each cycle. At `step`==SORT_CYCLES-1 → ROUTE with `step`=0.
- **ROUTE:** `step` increments each cycle. At `step`==ROUTE_CYCLES-1 → WRITE.
- **WRITE:** one cycle → DONE.
- **DONE:** one cycle → IDLE. `op_count` increments on entry to DONE.
- `abort`=1 in any non-IDLE state → IDLE on the next edge, with `step`=0. No `write_en` or `done` pulse follows, and `op_count` is unchanged.
- `abort` takes priority over every other transition, including the LOAD→SORT and ROUTE→WRITE transitions on the same cycle.
- `abort` in IDLE has no effect, and `abort` also wins over a simultaneous `start`.
- `start` outside IDLE is ignored; it is not queued.
- `start` held high continuously in IDLE launches back-to-back operations, with the next LOAD entered the cycle after DONE→IDLE.
- `pe_ready` is ignored outside LOAD.

## Timing
- Reset (async assert, synchronous deassert by the next `clk`):
  - state=IDLE, `step`=0, `op_count`=0;
  - `sort_en`, `sort_odd`, `route_en`, `write_en`, `busy` and `done` all 0.
- Nominal schedule, with `start` sampled at edge 0 and `pe_ready` all-1:
  - LOAD during cycle 1;
  - SORT during cycles 2..2+SORT_CYCLES-1 (2..22 at defaults);
  - ROUTE during cycles 23..28;
  - WRITE during cycle 29;
  - DONE during cycle 30;
  - IDLE from cycle 31.
- Start to `done` latency = 3 + SORT_CYCLES + ROUTE_CYCLES cycles (30 at defaults), plus any extra cycles spent waiting in LOAD.
- `busy` is high for exactly the cycles in which state≠IDLE, and `write_en` leads `done` by exactly one cycle.
- `rst` asserted mid-operation forces IDLE and drops all outputs immediately, without waiting for a clock edge.

## Structure
- Shared header `mesh_defs.vh` holds:
  - the state/phase codes (IDLE..DONE);
  - the `SORT_CYCLES` default;
  - the `ROUTE_CYCLES` expression, so that `mesh` and the PEs decode `phase` identically.
- One sub-module, `phase_counter`: STEP_W-bit counter with `clear`, `en` and a `terminal` output (count==limit-1, where `limit` is an input). The FSM uses it for both SORT and ROUTE.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0, `phase`=0. Assert `rst` at cycle 12 of an operation → outputs 0 before the next edge.
- `start` pulse at edge 0, `pe_ready`=16'hFFFF:
  - `sort_en` high for exactly 21 cycles with `step` 0..20 and `sort_odd` alternating 0,1,…;
  - `route_en` high for 6 cycles;
  - `write_en` at cycle 29, `done` at cycle 30;
  - `op_count`=1.
- `pe_ready`=16'hFFFE for 5 cycles, then 16'hFFFF → LOAD held for 6 cycles, and `done` at cycle 35.
- `abort` on the last SORT cycle (step=20) → IDLE next cycle, with no `route_en`, `write_en` or `done` pulse and `op_count` unchanged.
- `start` pulsed during ROUTE → ignored, giving a single `done`. Then `start` held high for 100 cycles → three `done` pulses, spaced 31 cycles apart, and `op_count`=4.
- Wrap check: run 256 operations → `op_count` returns to 0.

Source files
------------

// File: rtl/mesh_phase_ctrl_pkg.sv
// Shared definitions for the sorting-mesh sequencer: phase codes, default
// phase lengths and the phase-to-enable decode, so that the sequencer, the
// mesh and the PEs all interpret `phase` the same way.
package mesh_phase_ctrl_pkg;

  typedef logic [2:0] phase_t;

  // Phase codes broadcast on `phase`; codes 6 and 7 are never produced.
  localparam phase_t PH_IDLE  = 3'd0;
  localparam phase_t PH_LOAD  = 3'd1;
  localparam phase_t PH_SORT  = 3'd2;
  localparam phase_t PH_ROUTE = 3'd3;
  localparam phase_t PH_WRITE = 3'd4;
  localparam phase_t PH_DONE  = 3'd5;

  // Defaults for a 16-PE (4x4) mesh.
  localparam int SQRT_N_DEF      = 4;
  localparam int SORT_CYCLES_DEF = 21;

  // Route phase length: worst-case Manhattan distance across the mesh.
  function automatic int route_cycles_for(input int sqrt_n);
    return 2 * (sqrt_n - 1);
  endfunction

  // Per-phase control strobes seen by the PEs and the host.
  typedef struct packed {
    logic sort_en;
    logic sort_odd;
    logic route_en;
    logic write_en;
    logic busy;
    logic done;
  } phase_ctl_t;

  // Moore decode of the strobes from the phase code and the step LSB.
  function automatic phase_ctl_t decode_phase(input phase_t ph, input logic step_lsb);
    phase_ctl_t c;
    c          = '0;
    c.sort_en  = (ph == PH_SORT);
    c.sort_odd = (ph == PH_SORT) && step_lsb;
    c.route_en = (ph == PH_ROUTE);
    c.write_en = (ph == PH_WRITE);
    c.busy     = (ph != PH_IDLE);
    c.done     = (ph == PH_DONE);
    return c;
  endfunction

endpackage

// File: rtl/mesh_phase_ctrl_phase_counter.sv
// Step counter shared by the SORT and ROUTE phases. `terminal` flags the
// last step of the phase (count == limit-1) so the sequencer can leave it.
module phase_counter
  import mesh_phase_ctrl_pkg::*;
#(
  parameter int STEP_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [STEP_W:0]   limit,
  output logic [STEP_W-1:0] count,
  output logic              terminal
);

  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] count_d;

  // Clear has priority so a phase change always restarts the index at 0.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // limit is one bit wider than the count so a full 2^STEP_W phase fits.
  assign count    = count_q;
  assign terminal = ({1'b0, count_q} == (limit - 1'b1));

endmodule

// File: rtl/mesh_phase_ctrl.sv
// Sequencer for the sorting mesh: walks one write operation through
// LOAD, SORT, ROUTE, WRITE and DONE, broadcasting phase enables and a
// step index to every PE, and counts completed operations.
module mesh_phase_ctrl
  import mesh_phase_ctrl_pkg::*;
#(
  parameter int N            = 16,
  parameter int SQRT_N       = SQRT_N_DEF,
  parameter int SORT_CYCLES  = SORT_CYCLES_DEF,
  parameter int ROUTE_CYCLES = route_cycles_for(SQRT_N),
  parameter int STEP_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N-1:0]      pe_ready,
  output logic [2:0]        phase,
  output logic [STEP_W-1:0] step,
  output logic              sort_en,
  output logic              sort_odd,
  output logic              route_en,
  output logic              write_en,
  output logic              busy,
  output logic              done,
  output logic [7:0]        op_count
);

  localparam logic [STEP_W:0] SORT_LIM  = (STEP_W+1)'(SORT_CYCLES);
  localparam logic [STEP_W:0] ROUTE_LIM = (STEP_W+1)'(ROUTE_CYCLES);

  phase_t            state_q;
  phase_t            state_d;
  logic [7:0]        op_count_q;
  logic [7:0]        op_count_d;
  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_terminal;
  logic [STEP_W:0]   cnt_limit;
  logic [STEP_W-1:0] cnt_value;
  logic              all_ready;
  phase_ctl_t        ctl;

  assign all_ready = &pe_ready;

  // Next-phase logic; abort overrides every transition out of a busy phase.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b1;
    cnt_en    = 1'b0;
    cnt_limit = SORT_LIM;
    case (state_q)
      PH_IDLE: begin
        if (start && !abort) begin
          state_d = PH_LOAD;
        end
      end
      PH_LOAD: begin
        if (abort) begin
          state_d = PH_IDLE;
        end else if (all_ready) begin
          state_d = PH_SORT;
        end
      end
      PH_SORT: begin
        cnt_limit = SORT_LIM;
        if (abort) begin
          state_d = PH_IDLE;
        end else if (cnt_terminal) begin
          state_d = PH_ROUTE;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      PH_ROUTE: begin
        cnt_limit = ROUTE_LIM;
        if (abort) begin
          state_d = PH_IDLE;
        end else if (cnt_terminal) begin
          state_d = PH_WRITE;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      PH_WRITE: begin
        state_d = abort ? PH_IDLE : PH_DONE;
      end
      PH_DONE: begin
        state_d = PH_IDLE;
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase
  end

  // Completed-operation count advances on the WRITE->DONE edge only.
  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == PH_WRITE) && !abort) begin
      op_count_d = op_count_q + 8'd1;
    end
  end

  // Phase and operation-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PH_IDLE;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_count_q <= op_count_d;
    end
  end

  phase_counter #(
    .STEP_W (STEP_W)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .limit    (cnt_limit),
    .count    (cnt_value),
    .terminal (cnt_terminal)
  );

  // All outputs decode from registered state, so reset clears them at once.
  assign ctl      = decode_phase(state_q, cnt_value[0]);
  assign phase    = state_q;
  assign step     = (ctl.sort_en || ctl.route_en) ? cnt_value : '0;
  assign sort_en  = ctl.sort_en;
  assign sort_odd = ctl.sort_odd;
  assign route_en = ctl.route_en;
  assign write_en = ctl.write_en;
  assign busy     = ctl.busy;
  assign done     = ctl.done;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_mesh_phase_ctrl.sv
// Bench for mesh_phase_ctrl: table of operation scenarios plus hand-written
// sequences for reset, held start and counter wrap; `done` pulses are
// matched against a scoreboard of expected completion cycles and counts.
module tb_mesh_phase_ctrl;

  localparam int N      = 16;
  localparam int STEP_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [N-1:0]      pe_ready;
  logic [2:0]        phase;
  logic [STEP_W-1:0] step;
  logic              sort_en;
  logic              sort_odd;
  logic              route_en;
  logic              write_en;
  logic              busy;
  logic              done;
  logic [7:0]        op_count;

  always #5 clk = ~clk;

  mesh_phase_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pe_ready (pe_ready),
    .phase    (phase),
    .step     (step),
    .sort_en  (sort_en),
    .sort_odd (sort_odd),
    .route_en (route_en),
    .write_en (write_en),
    .busy     (busy),
    .done     (done),
    .op_count (op_count)
  );

  // Scenario: lw = cycles pe_ready stays incomplete, abort/pulse = cycle index
  // (1 = LOAD cycle after the start edge) at which abort/start is high, -1 none.
  typedef struct {
    int lw;
    int abort_cyc;
    int pulse_cyc;
    int exp_load;
    int exp_sort;
    int exp_route;
    int exp_wr;
    int exp_done;
    int exp_busy;
  } vec_t;

  typedef struct {
    int         exp_cyc;
    logic [7:0] exp_opc;
  } sb_t;

  vec_t       vecs[8];
  sb_t        sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] op_model;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_vec();
    return {10'd0, phase, step, sort_en, sort_odd, route_en, write_en, busy, done, op_count};
  endfunction

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.exp_cyc);
        check("done_op_count", int'(op_count), int'(e.exp_opc));
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  nload, nsort, nroute, nbusy, wr_cyc, done_cyc;
    bit  seq_ok, ended;
    sb_t e;
    nload = 0; nsort = 0; nroute = 0; nbusy = 0; wr_cyc = 0; done_cyc = 0;
    seq_ok = 1'b1; ended = 1'b0;
    if (v.exp_done != 0) begin
      op_model  = op_model + 8'd1;
      e.exp_cyc = cyc + v.exp_done;
      e.exp_opc = op_model;
      sb_q.push_back(e);
    end
    start    = 1'b1;
    abort    = 1'b0;
    pe_ready = (v.lw > 0) ? 16'hFFFE : 16'hFFFF;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (!busy) begin
        ended = 1'b1;
        if (phase != 3'd0) seq_ok = 1'b0;
        break;
      end
      nbusy++;
      if (phase == 3'd1) nload++;
      if (sort_en) begin
        if (int'(step) != nsort || sort_odd != nsort[0] || phase != 3'd2 || route_en) seq_ok = 1'b0;
        nsort++;
      end else if (route_en) begin
        if (int'(step) != nroute || phase != 3'd3) seq_ok = 1'b0;
        nroute++;
      end else if (step != '0 || sort_odd) begin
        seq_ok = 1'b0;
      end
      if (write_en) wr_cyc = k;
      if (done) done_cyc = k;
      start    = (k == v.pulse_cyc);
      abort    = (k == v.abort_cyc);
      pe_ready = (k > v.lw) ? 16'hFFFF : 16'hFFFE;
    end
    start = 1'b0;
    abort = 1'b0;
    check($sformatf("v%0d_terminated", idx), int'(ended), 1);
    check($sformatf("v%0d_load_cycles", idx), nload, v.exp_load);
    check($sformatf("v%0d_sort_cycles", idx), nsort, v.exp_sort);
    check($sformatf("v%0d_route_cycles", idx), nroute, v.exp_route);
    check($sformatf("v%0d_write_cycle", idx), wr_cyc, v.exp_wr);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_busy_cycles", idx), nbusy, v.exp_busy);
    check($sformatf("v%0d_step_sequence", idx), int'(seq_ok), 1);
    check($sformatf("v%0d_op_count", idx), int'(op_count), int'(op_model));
  endtask

  initial begin
    int  nd;
    sb_t e;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    pe_ready = '0;
    op_model = '0;

    //           lw abort pulse load sort route wr done busy
    vecs[0] = '{0, -1,   -1,   1,   21,  6,    29, 30,  30};
    vecs[1] = '{5, -1,   -1,   6,   21,  6,    34, 35,  35};
    vecs[2] = '{0, 22,   -1,   1,   21,  0,    0,  0,   22};
    vecs[3] = '{0, -1,   25,   1,   21,  6,    29, 30,  30};
    vecs[4] = '{0, 1,    -1,   1,   0,   0,    0,  0,   1};
    vecs[5] = '{0, 28,   -1,   1,   21,  6,    0,  0,   28};
    vecs[6] = '{0, 29,   -1,   1,   21,  6,    29, 0,   29};
    vecs[7] = '{3, 2,    -1,   2,   0,   0,    0,  0,   2};

    // Reset state, then an idle stretch.
    tick();
    check("reset_outputs", out_vec(), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_outputs_%0d", i), out_vec(), 0);
    end

    // abort alone in IDLE, then abort together with start.
    abort = 1'b1;
    tick();
    check("abort_in_idle", out_vec(), 0);
    start = 1'b1;
    tick();
    check("abort_beats_start", out_vec(), 0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset asserted between edges in the middle of SORT.
    start    = 1'b1;
    pe_ready = 16'hFFFF;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 12; k++) tick();
    check("pre_reset_sort_en", int'(sort_en), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", out_vec(), 0);
    tick();
    rst      = 1'b0;
    op_model = '0;
    tick();
    check("post_reset_idle", out_vec(), 0);

    // 256 back-to-back operations: op_count must wrap to 0.
    for (int i = 0; i < 256; i++) begin
      op_model  = op_model + 8'd1;
      e.exp_cyc = cyc + 30 + 31 * i;
      e.exp_opc = op_model;
      sb_q.push_back(e);
    end
    start = 1'b1;
    nd    = 0;
    for (int k = 1; k <= 7945; k++) begin
      tick();
      if (done) nd++;
      if (k == 7906) start = 1'b0;
    end
    check("wrap_done_count", nd, 256);
    check("wrap_op_count", int'(op_count), 0);

    // start held high: back-to-back operations 31 cycles apart.
    for (int i = 0; i < 3; i++) begin
      op_model  = op_model + 8'd1;
      e.exp_cyc = cyc + 30 + 31 * i;
      e.exp_opc = op_model;
      sb_q.push_back(e);
    end
    start = 1'b1;
    nd    = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done) nd++;
      if (k == 90) start = 1'b0;
    end
    check("held_start_done_count", nd, 3);
    check("held_start_op_count", int'(op_count), 3);
    check("held_start_final_phase", int'(phase), 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
